risc_toy_fetch_unit: RTL

//   Instruction fetch front-end of the RISC_TOY pipeline. Drives the IMEM port
//   (IREQ/IADDR, INSTR returned one cycle later) and buffers fetched words with

---
 rtl/risc_toy_fetch_unit_if.sv | 29 ++
 rtl/risc_toy_fetch_unit.sv | 90 +++++++++
 2 files changed

// File: rtl/risc_toy_fetch_unit_if.sv
// IMEM, redirect and decode-side signals of the RISC_TOY fetch unit.
// "master" is the fetch unit side; "slave" is the memory/decode environment side.
interface risc_toy_fetch_unit_if #(
  parameter int AW    = 30,
  parameter int DEPTH = 4
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic          IREQ;
  logic [AW-1:0] IADDR;
  logic [31:0]   INSTR;
  logic          REDIR_VLD;
  logic [AW-1:0] REDIR_ADDR;
  logic          ID_VALID;
  logic          ID_READY;
  logic [31:0]   ID_INSTR;
  logic [AW-1:0] ID_PC;
  logic [OW-1:0] OCC;

  modport master (
    output IREQ, IADDR, ID_VALID, ID_INSTR, ID_PC, OCC,
    input  INSTR, REDIR_VLD, REDIR_ADDR, ID_READY
  );

  modport slave (
    input  IREQ, IADDR, ID_VALID, ID_INSTR, ID_PC, OCC,
    output INSTR, REDIR_VLD, REDIR_ADDR, ID_READY
  );
endinterface

// File: rtl/risc_toy_fetch_unit.sv
// RISC_TOY instruction fetch front-end: credit-limited IMEM issue, prefetch FIFO
// of {INSTR, PC} toward decode, and zero-bubble flush/restart on redirect.
module risc_toy_fetch_unit #(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 30,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  risc_toy_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [AW-1:0] fpc;
  logic [AW-1:0] rsp_pc;
  logic [AW-1:0] iaddr;
  logic          inflight;
  logic          credit;
  logic          ireq;
  logic          push;
  logic          pop;
  logic          id_valid;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [OW-1:0] occ;
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] mem_pc    [DEPTH];
  logic [31:0]   hold_instr;
  logic [AW-1:0] hold_pc;

  // Credit counts the response already on its way so a push can never overflow.
  assign credit   = (int'(occ) + int'(inflight)) < DEPTH;
  assign ireq     = RSTN & (bus.REDIR_VLD | credit);
  assign iaddr    = bus.REDIR_VLD ? bus.REDIR_ADDR : fpc;
  assign id_valid = (occ != '0) & ~bus.REDIR_VLD;
  assign push     = inflight & ~bus.REDIR_VLD;
  assign pop      = id_valid & bus.ID_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fpc        <= RESET_PC;
      rsp_pc     <= '0;
      inflight   <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      occ        <= '0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      inflight <= ireq;
      if (ireq) begin
        rsp_pc <= iaddr;
        fpc    <= iaddr + AW'(1);
      end
      if (bus.REDIR_VLD) begin
        wptr <= '0;
        rptr <= '0;
        occ  <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        case ({push, pop})
          2'b10:   occ <= occ + OW'(1);
          2'b01:   occ <= occ - OW'(1);
          default: ;
        endcase
      end
      // Remember the last head shown so the outputs hold while the FIFO is empty.
      if (occ != '0) begin
        hold_instr <= mem_instr[rptr];
        hold_pc    <= mem_pc[rptr];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_instr[wptr] <= bus.INSTR;
      mem_pc[wptr]    <= rsp_pc;
    end
  end

  assign bus.IREQ     = ireq;
  assign bus.IADDR    = iaddr;
  assign bus.ID_VALID = id_valid;
  assign bus.ID_INSTR = (occ != '0) ? mem_instr[rptr] : hold_instr;
  assign bus.ID_PC    = (occ != '0) ? mem_pc[rptr]    : hold_pc;
  assign bus.OCC      = occ;
endmodule
